// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: PC generation, ROM issue, {pc, inst} prefetch FIFO to decode.
// Optional IF_BYPASS_EN: a return arriving into an empty FIFO is presented to decode in the same cycle.
module if_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     rom_ce_o,
  output logic [31:0]              rom_addr_o,
  input  logic [31:0]              rom_data_i,
  input  logic                     branch_flag_i,
  input  logic [31:0]              branch_target_i,
  output logic                     if_valid_o,
  output logic [31:0]              if_pc_o,
  output logic [31:0]              if_inst_o,
  input  logic                     if_ready_i,
  output logic [$clog2(DEPTH):0]   fifo_count_o
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned SW  = CW + 1;
  localparam logic [SW-1:0] DEPTH_C = SW'(DEPTH);

  logic [31:0]   pc_q;
  logic [31:0]   pending_pc_q;
  logic          inflight_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   mem_pc   [DEPTH];
  logic [31:0]   mem_inst [DEPTH];

  logic [SW-1:0] credit_sum;
  logic          issue;
  logic          fifo_valid;
  logic          byp_valid;
  logic          deliver;
  logic          push;
  logic          pop;

  // Credit counts the outstanding return too, so a push can never land on a full FIFO.
  assign credit_sum = SW'(count_q) + SW'(inflight_q);
  assign issue      = rst & ~branch_flag_i & (credit_sum < DEPTH_C);

  assign rom_ce_o     = issue;
  assign rom_addr_o   = pc_q;
  assign fifo_count_o = count_q;

  assign fifo_valid = (count_q != '0);

`ifdef IF_BYPASS_EN
  assign byp_valid = ~fifo_valid & inflight_q;
`else
  assign byp_valid = 1'b0;
`endif

  assign if_valid_o = fifo_valid | byp_valid;
  assign deliver    = if_valid_o & if_ready_i & ~branch_flag_i;
  assign pop        = deliver & fifo_valid;
  // A bypassed return that decode takes is consumed, not stored.
  assign push       = inflight_q & ~branch_flag_i & ~(deliver & byp_valid);

  always_comb begin
    if_pc_o   = '0;
    if_inst_o = '0;
    if (fifo_valid) begin
      if_pc_o   = mem_pc[rd_ptr_q];
      if_inst_o = mem_inst[rd_ptr_q];
    end else if (byp_valid) begin
      if_pc_o   = pending_pc_q;
      if_inst_o = rom_data_i;
    end
  end

  // Issue is blocked while branch_flag_i is high, so no return can follow a flush;
  // clearing inflight_q discards whatever is still pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q         <= RESET_PC;
      pending_pc_q <= '0;
      inflight_q   <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else if (branch_flag_i) begin
      pc_q       <= branch_target_i;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q         <= pc_q + PC_STEP;
        pending_pc_q <= pc_q;
      end
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr_q]   <= pending_pc_q;
      mem_inst[wr_ptr_q] <= rom_data_i;
    end
  end

endmodule
